// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencing for the 5-stage RISC-V pipeline: load-use stalls, branch flushes,
// data-memory freezes and the SYSCALL drain to HALTED. Perf counters exist only with PIPELINE_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_halt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic        mem_access,
    input  logic        dmem_ack,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        pipe_freeze,
    output logic        dmem_req,
    output logic        halted,
    output logic        mem_timeout,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_e;

    localparam logic [8:0] TIMEOUT = 9'(MEM_TIMEOUT);

    state_e      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [7:0]  dwait_q, dwait_d;
    logic [1:0]  drain_q, drain_d;
    logic        mem_to_q, mem_to_d;
    logic [8:0]  wait_inc, dwait_inc;
    logic        load_use, freeze_req;
    logic        pc_w, ifid_w, flush, bubble, freeze, req, halt;

    assign load_use   = ex_mem_read & (ex_rd != 5'd0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    assign freeze_req = mem_access & ~dmem_ack;
    assign wait_inc   = {1'b0, wait_q} + 9'd1;
    assign dwait_inc  = {1'b0, dwait_q} + 9'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RUN;
            wait_q   <= '0;
            dwait_q  <= '0;
            drain_q  <= '0;
            mem_to_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            dwait_q  <= dwait_d;
            drain_q  <= drain_d;
            mem_to_q <= mem_to_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        dwait_d  = dwait_q;
        drain_d  = drain_q;
        mem_to_d = mem_to_q;
        pc_w     = 1'b1;
        ifid_w   = 1'b1;
        flush    = 1'b0;
        bubble   = 1'b0;
        freeze   = 1'b0;
        req      = mem_access;
        halt     = 1'b0;
        case (state_q)
            // wait_q is always 0 in RUN, so the same increment seeds the first wait cycle
            RUN, MEM_WAIT: begin
                if (freeze_req) begin
                    freeze = 1'b1;
                    pc_w   = 1'b0;
                    ifid_w = 1'b0;
                    if (wait_inc == TIMEOUT) begin
                        state_d  = HALTED;
                        mem_to_d = 1'b1;
                    end else begin
                        state_d = MEM_WAIT;
                        wait_d  = wait_inc[7:0];
                    end
                end else begin
                    state_d = RUN;
                    wait_d  = '0;
                    if (ex_branch_taken) begin
                        flush  = 1'b1;
                        bubble = 1'b1;
                    end else if (id_halt) begin
                        pc_w    = 1'b0;
                        ifid_w  = 1'b0;
                        bubble  = 1'b1;
                        state_d = DRAIN;
                        drain_d = 2'd3;
                        dwait_d = '0;
                    end else if (load_use) begin
                        pc_w   = 1'b0;
                        ifid_w = 1'b0;
                        bubble = 1'b1;
                    end
                end
            end
            DRAIN: begin
                pc_w   = 1'b0;
                ifid_w = 1'b0;
                bubble = 1'b1;
                if (freeze_req) begin
                    freeze = 1'b1;
                    if (dwait_inc == TIMEOUT) begin
                        state_d  = HALTED;
                        mem_to_d = 1'b1;
                    end else begin
                        dwait_d = dwait_inc[7:0];
                    end
                end else begin
                    dwait_d = '0;
                    drain_d = drain_q - 2'd1;
                    if (drain_q == 2'd1) begin
                        state_d = HALTED;
                    end
                end
            end
            HALTED: begin
                pc_w   = 1'b0;
                ifid_w = 1'b0;
                freeze = 1'b1;
                req    = 1'b0;
                halt   = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    // Reset forces the stalled/bubbled output pattern without waiting for a clock
    assign pc_write     = reset_n & pc_w;
    assign if_id_write  = reset_n & ifid_w;
    assign if_id_flush  = reset_n & flush;
    assign id_ex_bubble = ~reset_n | bubble;
    assign pipe_freeze  = reset_n & freeze;
    assign dmem_req     = reset_n & req;
    assign halted       = reset_n & halt;
    assign mem_timeout  = reset_n & mem_to_q;

`ifdef PIPELINE_PERF_CNT_EN
    logic [15:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if ((state_q != HALTED) && !pc_w && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
            if (flush && (flush_q != 16'hFFFF)) begin
                flush_q <= flush_q + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = 16'h0000;
    assign flush_count  = 16'h0000;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized bench for pipeline_hazard_ctrl, checked against a cycle-level
// behavioural model (drain/wait bookkeeping held in plain integers).
module tb_pipeline_hazard_ctrl;

    localparam int TMO = 4;
`ifdef PIPELINE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_halt, ex_mem_read, ex_branch_taken, mem_access, dmem_ack;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze;
    logic        dmem_req, halted, mem_timeout;
    logic [15:0] stall_cycles, flush_count;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_halt(id_halt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .mem_access(mem_access), .dmem_ack(dmem_ack),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .pipe_freeze(pipe_freeze), .dmem_req(dmem_req),
        .halted(halted), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    // Model state
    int m_halted, m_to, m_drain, m_unacked, m_stall, m_flush;
    bit e_pc, e_ifid, e_flush, e_bub, e_frz, e_req, e_halt, e_to;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_halt = 0; ex_mem_read = 0;
        ex_branch_taken = 0; mem_access = 0; dmem_ack = 0;
    endtask

    task automatic model_reset();
        m_halted = 0; m_to = 0; m_drain = 0; m_unacked = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_eval();
        bit fr, lu;
        fr = mem_access && !dmem_ack;
        lu = ex_mem_read && (ex_rd != 0) && (ex_rd == id_rs1 || ex_rd == id_rs2);
        e_pc = 1; e_ifid = 1; e_flush = 0; e_bub = 0; e_frz = 0; e_req = mem_access;
        e_halt = (m_halted != 0); e_to = (m_to != 0);
        if (m_halted != 0) begin
            e_pc = 0; e_ifid = 0; e_frz = 1; e_req = 0;
        end else if (m_drain > 0) begin
            e_pc = 0; e_ifid = 0; e_bub = 1; e_frz = fr;
        end else if (fr) begin
            e_pc = 0; e_ifid = 0; e_frz = 1;
        end else if (ex_branch_taken) begin
            e_flush = 1; e_bub = 1;
        end else if (id_halt || lu) begin
            e_pc = 0; e_ifid = 0; e_bub = 1;
        end
    endtask

    task automatic model_commit();
        bit fr;
        fr = mem_access && !dmem_ack;
        if (m_halted == 0) begin
            if (!e_pc && m_stall < 65535) m_stall++;
            if (e_flush && m_flush < 65535) m_flush++;
            if (fr) begin
                m_unacked++;
                if (m_unacked == TMO) begin
                    m_halted = 1;
                    m_to = 1;
                end
            end else begin
                m_unacked = 0;
                if (m_drain > 0) begin
                    m_drain--;
                    if (m_drain == 0) m_halted = 1;
                end else if (!ex_branch_taken && id_halt) begin
                    m_drain = 3;
                end
            end
        end
    endtask

    // Called just after a falling edge with inputs already driven
    task automatic settle();
        #1;
        model_eval();
        chk("pc_write", 32'(pc_write), 32'(e_pc));
        chk("if_id_write", 32'(if_id_write), 32'(e_ifid));
        chk("if_id_flush", 32'(if_id_flush), 32'(e_flush));
        chk("id_ex_bubble", 32'(id_ex_bubble), 32'(e_bub));
        chk("pipe_freeze", 32'(pipe_freeze), 32'(e_frz));
        chk("dmem_req", 32'(dmem_req), 32'(e_req));
        chk("halted", 32'(halted), 32'(e_halt));
        chk("mem_timeout", 32'(mem_timeout), 32'(e_to));
        chk("stall_cycles", 32'(stall_cycles), PERF ? 32'(m_stall) : 32'd0);
        chk("flush_count", 32'(flush_count), PERF ? 32'(m_flush) : 32'd0);
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"}, 32'(pc_write), 32'd0);
        chk({tag, "_ifid"}, 32'(if_id_write), 32'd0);
        chk({tag, "_bub"}, 32'(id_ex_bubble), 32'd1);
        chk({tag, "_flush"}, 32'(if_id_flush), 32'd0);
        chk({tag, "_frz"}, 32'(pipe_freeze), 32'd0);
        chk({tag, "_req"}, 32'(dmem_req), 32'd0);
        chk({tag, "_halt"}, 32'(halted), 32'd0);
        chk({tag, "_to"}, 32'(mem_timeout), 32'd0);
        chk({tag, "_stall"}, 32'(stall_cycles), 32'd0);
        chk({tag, "_fcnt"}, 32'(flush_count), 32'd0);
    endtask

    // Asserts reset mid-cycle (between edges), checks immediately, releases on a falling edge
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("rst_async");
        model_reset();
        @(posedge clk);
        #1 chk_reset_vals("rst_hold");
        @(negedge clk);
        reset_n = 1'b1;
        set_idle();
    endtask

    initial begin
        reset_n = 1'b0;
        set_idle();
        model_reset();
        @(negedge clk);
        do_reset();

        // Load-use on rs2, then the same hazard with rd=x0
        ex_mem_read = 1; ex_rd = 5; id_rs2 = 5;
        settle();
        chk("lu_pc", 32'(pc_write), 32'd0);
        chk("lu_bub", 32'(id_ex_bubble), 32'd1);
        advance();
        ex_mem_read = 0; settle(); advance();
        ex_mem_read = 1; ex_rd = 0; id_rs2 = 0;
        settle();
        chk("lu_x0_pc", 32'(pc_write), 32'd1);
        advance();

        // Branch overrides load-use
        do_reset();
        ex_mem_read = 1; ex_rd = 7; id_rs1 = 7; ex_branch_taken = 1;
        settle();
        chk("br_flush", 32'(if_id_flush), 32'd1);
        chk("br_pc", 32'(pc_write), 32'd1);
        advance();
        set_idle(); settle();
        chk("br_fcnt", 32'(flush_count), PERF ? 32'd1 : 32'd0);
        advance();

        // Memory wait with ack on the third cycle
        do_reset();
        mem_access = 1; dmem_ack = 0;
        settle(); chk("mw_frz1", 32'(pipe_freeze), 32'd1); advance();
        settle(); chk("mw_frz2", 32'(pipe_freeze), 32'd1); advance();
        dmem_ack = 1;
        settle(); chk("mw_ack_frz", 32'(pipe_freeze), 32'd0); advance();
        set_idle(); settle();
        chk("mw_stall", 32'(stall_cycles), PERF ? 32'd2 : 32'd0);
        advance();

        // Memory timeout
        do_reset();
        mem_access = 1; dmem_ack = 0;
        for (int i = 0; i < TMO; i++) begin
            settle(); chk("to_req", 32'(dmem_req), 32'd1); advance();
        end
        settle();
        chk("to_halt", 32'(halted), 32'd1);
        chk("to_flag", 32'(mem_timeout), 32'd1);
        chk("to_req_off", 32'(dmem_req), 32'd0);
        advance();

        // SYSCALL drain, halted is sticky
        do_reset();
        id_halt = 1; settle(); advance();
        id_halt = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("dr_bub", 32'(id_ex_bubble), 32'd1);
            chk("dr_nohalt", 32'(halted), 32'd0);
            advance();
        end
        for (int i = 0; i < 3; i++) begin
            settle(); chk("dr_halt", 32'(halted), 32'd1); advance();
        end

        // Reset in the middle of DRAIN
        do_reset();
        id_halt = 1; settle(); advance();
        id_halt = 0; settle(); advance();
        do_reset();
        settle();
        chk("post_rst_halt", 32'(halted), 32'd0);
        chk("post_rst_pc", 32'(pc_write), 32'd1);
        advance();

        // Randomized episodes with varying ack likelihood
        for (int ep = 0; ep < 16; ep++) begin
            int ackw;
            ackw = ep % 8;
            do_reset();
            for (int c = 0; c < 60; c++) begin
                ex_mem_read     = 1'($urandom % 2);
                ex_rd           = 5'($urandom % 4);
                id_rs1          = 5'($urandom % 4);
                id_rs2          = 5'($urandom % 4);
                id_halt         = ($urandom % 16) == 0;
                ex_branch_taken = ($urandom % 5) == 0;
                mem_access      = ($urandom % 3) == 0;
                dmem_ack        = ($urandom % 8) < ackw;
                if (($urandom % 64) == 0) begin
                    do_reset();
                end else begin
                    settle();
                    advance();
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
